// File: rtl/tt_rr7_pkg.sv
// ============================================================================
// Module   : tt_rr7_pkg
// Brief    : Shared types and constants for the round-robin 7-segment arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_rr7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Active-low segment codes, entry i at bits [7*i +: 7]; bit 6 is segment a.
  localparam logic [7:0][6:0] SEG_TABLE = {
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational round-robin pick: first set request at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick (
  input  logic [7:0] i_req,
  input  logic [2:0] i_ptr,
  output logic [2:0] o_idx,
  output logic       o_any
);

  logic [15:0] w_dbl;
  logic [7:0]  w_rot;
  logic [2:0]  w_ffs;

  // Rotate so that the pointer position lands on bit 0.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[7:0];

  always_comb begin
    w_ffs = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_ffs = i[2:0];
    end
  end

  assign o_idx = w_ffs + i_ptr;
  assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/tt_um_rr_arbiter_7seg.sv
// ============================================================================
// Module   : tt_um_rr_arbiter_7seg
// Brief    : Eight-way round-robin arbiter with bounded tenure driving a 7-seg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_rr_arbiter_7seg
  import tt_rr7_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui,
  output logic [7:0] uo,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_idx;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_seg;
  logic             r_to;
  logic             r_gv;

  logic [2:0]       w_pick_idx;
  logic             w_pick_any;
  logic             w_drop;
  logic             w_rel;
  logic             w_tmo;
  logic             w_exit;
  logic             w_unused;

  rr_priority_pick u_pick (
    .i_req (ui),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_drop = ~ui[r_idx];
  assign w_rel  = uio_in[0];
  assign w_tmo  = (r_cnt == C_CNT_MAX) && !uio_in[1];

  always_comb begin
    w_state_next = r_state;
    w_exit       = 1'b0;
    case (r_state)
      IDLE:  if (w_pick_any) w_state_next = GRANT;
      GRANT: begin
        if (w_drop || w_rel || w_tmo) begin
          w_exit       = 1'b1;
          w_state_next = GAP;
        end
      end
      GAP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_ptr   <= 3'd0;
      r_cnt   <= '0;
      r_seg   <= SEG_BLANK;
      r_to    <= 1'b0;
      r_gv    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_idx <= w_pick_idx;
            r_cnt <= '0;
            r_gv  <= 1'b1;
            r_seg <= SEG_TABLE[w_pick_idx];
          end
        end
        GRANT: begin
          if (w_exit) begin
            r_ptr <= r_idx + 3'd1;
            r_gv  <= 1'b0;
            r_seg <= SEG_BLANK;
            // Flag only a pure timeout; a coincident release or drop wins.
            r_to  <= w_tmo && !w_drop && !w_rel;
          end else if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP:     r_to <= 1'b0;
        default: ;
      endcase
    end
  end

  assign uo      = {r_to, r_seg};
  assign uio_out = {r_gv, r_idx & {3{r_gv}}, 4'b0000};
  assign uio_oe  = 8'hF0;

  assign w_unused = &{ena, uio_in[7:2], 1'b0};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_rr_arbiter_7seg.sv
// ============================================================================
// Module   : tb_tt_um_rr_arbiter_7seg
// Brief    : Scoreboard bench with a grant-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_rr_arbiter_7seg;

  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic       ena = 1'b1;
  logic [7:0] uo;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_rr_arbiter_7seg #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui      (ui),
    .uo      (uo),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_cyc    = 0;

  // Reference model: current owner (-1 = none), clocks already shown,
  // next-search start position, and whether the one-clock gap is pending.
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_gap;
  bit m_to;

  function automatic logic [6:0] seg_of(input int i);
    case (i)
      0: return 7'h01;
      1: return 7'h4F;
      2: return 7'h12;
      3: return 7'h06;
      4: return 7'h4C;
      5: return 7'h24;
      6: return 7'h20;
      default: return 7'h0F;
    endcase
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_gap   = 1'b0;
    m_to    = 1'b0;
  endfunction

  function automatic exp_t model_step(input logic [7:0] u, input bit rel, input bit lk);
    exp_t e;
    bit   found;
    bit   drop;
    bit   tmo;
    found = 1'b0;
    if (m_gap) begin
      m_gap = 1'b0;
      m_to  = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (!found && u[(m_ptr + k) % 8]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % 8;
          m_held  = 0;
        end
      end
    end else begin
      drop   = !u[m_owner];
      tmo    = (m_held + 1 >= HOLD) && !lk;
      m_held = m_held + 1;
      if (drop || rel || tmo) begin
        m_to    = tmo && !drop && !rel;
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end
    e.uo  = {m_to, (m_owner >= 0) ? seg_of(m_owner) : 7'h7F};
    e.uio = (m_owner >= 0) ? {1'b1, 3'(m_owner), 4'b0000} : 8'h00;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  // Called at a falling edge: apply inputs, predict the post-edge outputs.
  task automatic drive(input logic [7:0] u, input bit rel, input bit lk);
    ui     = u;
    uio_in = {6'b000000, lk, rel};
    sb_q.push_back(model_step(u, rel, lk));
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    n_cyc++;
    if (rst_n && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk($sformatf("cycle%0d uo/uio_out", n_cyc), {uo, uio_out}, {mon_e.uo, mon_e.uio});
    end
  end

  initial begin
    logic [7:0] ru;
    model_reset();
    rst_n  = 1'b0;
    ui     = 8'hFF;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset uo", {8'h00, uo}, 16'h007F);
    chk("reset uio_out", {8'h00, uio_out}, 16'h0000);
    chk("reset uio_oe", {8'h00, uio_oe}, 16'h00F0);

    rst_n = 1'b1;
    drive(8'hFF, 1'b0, 1'b0);

    // Fairness: every owner releases after three clocks shown.
    repeat (45) drive(8'hFF, (m_owner >= 0) && (m_held == 2), 1'b0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // Timeout on a lone holder.
    repeat (40) drive(8'h20, 1'b0, 1'b0);

    // Locked holder, then request dropped.
    repeat (40) drive(8'h20, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // Release on the very clock the tenure expires.
    for (int i = 0; i < 60; i++) begin
      if ((m_owner >= 0) && (m_held == HOLD - 1)) begin
        drive(8'h20, 1'b1, 1'b0);
        break;
      end
      drive(8'h20, 1'b0, 1'b0);
    end
    repeat (3) drive(8'h60, 1'b0, 1'b0);
    repeat (3) drive(8'h40, 1'b0, 1'b1);

    // Asynchronous reset while index 6 holds the display.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset uo", {8'h00, uo}, 16'h007F);
    chk("async reset uio_out", {8'h00, uio_out}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) drive(8'hC1, 1'b0, 1'b0);

    // Randomised traffic with sticky request vectors.
    ru = 8'($urandom);
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) ru = 8'($urandom) & 8'($urandom);
      drive(ru, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end

    @(negedge clk);
    chk("scoreboard drained", 16'(sb_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
